// File: rtl/udp_fifo_pkg.sv
// Shared constants and helpers for the parametrised UDP command FIFO.
package udp_fifo_pkg;

  localparam int unsigned FIFO_MODE_STD   = 0;
  localparam int unsigned FIFO_MODE_FWFT  = 1;

  localparam int unsigned DEPTH_WIDTH_MIN = 2;
  localparam int unsigned DEPTH_WIDTH_MAX = 12;
  localparam int unsigned DATA_WIDTH_MAX  = 1152;

  // One extra wrap bit above the address bits.
  function automatic int unsigned ptr_width(input int unsigned depth_width);
    return depth_width + 1;
  endfunction

endpackage

// File: rtl/udp_cmd_sync_fifo_param_if.sv
// Writer/reader/status bundle between the UDP command parser, executor and the FIFO.
interface udp_cmd_sync_fifo_param_if
  import udp_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 33,
  parameter int unsigned DEPTH_WIDTH = 6
);
  localparam int unsigned PTR_WIDTH = ptr_width(DEPTH_WIDTH);

  logic                  flush;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_full;
  logic                  almost_full;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_empty;
  logic                  almost_empty;
  logic [PTR_WIDTH-1:0]  af_thresh;
  logic [PTR_WIDTH-1:0]  ae_thresh;
  logic [PTR_WIDTH-1:0]  level;
  logic                  overflow;
  logic                  underflow;
  logic                  err_clr;

  modport master (
    output flush, wr_en, wr_data, rd_en, af_thresh, ae_thresh, err_clr,
    input  wr_full, almost_full, rd_data, rd_empty, almost_empty, level, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en, af_thresh, ae_thresh, err_clr,
    output wr_full, almost_full, rd_data, rd_empty, almost_empty, level, overflow, underflow
  );

endinterface

// File: rtl/udp_fifo_ctrl.sv
// FIFO bookkeeping: pointers, fill level, request accept, status flags and sticky errors.
module udp_fifo_ctrl
  import udp_fifo_pkg::*;
#(
  parameter int unsigned DEPTH_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic                   err_clr,
  input  logic [DEPTH_WIDTH:0]   af_thresh,
  input  logic [DEPTH_WIDTH:0]   ae_thresh,
  output logic                   wr_acc_c,
  output logic                   rd_acc_c,
  output logic [DEPTH_WIDTH-1:0] wr_addr,
  output logic [DEPTH_WIDTH-1:0] rd_addr,
  output logic [DEPTH_WIDTH:0]   level,
  output logic                   wr_full_c,
  output logic                   almost_full_c,
  output logic                   rd_empty_c,
  output logic                   almost_empty_c,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int unsigned    PW    = ptr_width(DEPTH_WIDTH);
  localparam logic [PW-1:0]  DEPTH = PW'(1) << DEPTH_WIDTH;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          ovf_set_c;
  logic          udf_set_c;

  assign wr_addr = wr_ptr[DEPTH_WIDTH-1:0];
  assign rd_addr = rd_ptr[DEPTH_WIDTH-1:0];

  // Flags come straight off the level register; flush masks both requests and their errors.
  always_comb begin
    wr_full_c      = (level == DEPTH);
    rd_empty_c     = (level == '0);
    almost_full_c  = (level >= af_thresh);
    almost_empty_c = (level <= ae_thresh);
    wr_acc_c       = wr_en & ~wr_full_c  & ~flush;
    rd_acc_c       = rd_en & ~rd_empty_c & ~flush;
    ovf_set_c      = wr_en &  wr_full_c  & ~flush;
    udf_set_c      = rd_en &  rd_empty_c & ~flush;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_acc_c) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc_c) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_acc_c, rd_acc_c})
        2'b10:   level <= level + PW'(1);
        2'b01:   level <= level - PW'(1);
        default: level <= level;
      endcase
    end
  end

  // A new error wins over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set_c)    overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
      if (udf_set_c)    underflow <= 1'b1;
      else if (err_clr) underflow <= 1'b0;
    end
  end

endmodule

// File: rtl/udp_cmd_sync_fifo_param.sv
// Parametrised single-clock command FIFO: storage array and read path around udp_fifo_ctrl.
module udp_cmd_sync_fifo_param
  import udp_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 33,
  parameter int unsigned DEPTH_WIDTH = 6,
  parameter int unsigned FWFT        = FIFO_MODE_STD
) (
  input  logic                       clk,
  input  logic                       rstn,
  udp_cmd_sync_fifo_param_if.slave   bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_WIDTH;

  if (DEPTH_WIDTH < DEPTH_WIDTH_MIN || DEPTH_WIDTH > DEPTH_WIDTH_MAX) begin : g_bad_depth
    $error("udp_cmd_sync_fifo_param: DEPTH_WIDTH out of range");
  end
  if (DATA_WIDTH == 0 || DATA_WIDTH > DATA_WIDTH_MAX) begin : g_bad_width
    $error("udp_cmd_sync_fifo_param: DATA_WIDTH out of range");
  end

  logic                   wr_acc;
  logic                   rd_acc;
  logic [DEPTH_WIDTH-1:0] wr_addr;
  logic [DEPTH_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];

  udp_fifo_ctrl #(.DEPTH_WIDTH(DEPTH_WIDTH)) u_ctrl (
    .clk            (clk),
    .rstn           (rstn),
    .flush          (bus.flush),
    .wr_en          (bus.wr_en),
    .rd_en          (bus.rd_en),
    .err_clr        (bus.err_clr),
    .af_thresh      (bus.af_thresh),
    .ae_thresh      (bus.ae_thresh),
    .wr_acc_c       (wr_acc),
    .rd_acc_c       (rd_acc),
    .wr_addr        (wr_addr),
    .rd_addr        (rd_addr),
    .level          (bus.level),
    .wr_full_c      (bus.wr_full),
    .almost_full_c  (bus.almost_full),
    .rd_empty_c     (bus.rd_empty),
    .almost_empty_c (bus.almost_empty),
    .overflow       (bus.overflow),
    .underflow      (bus.underflow)
  );

  // Storage is deliberately not reset so it maps onto RAM/LUT arrays.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_addr] <= bus.wr_data;
  end

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    // Head word shown directly; forced to zero while empty to keep X off the bus.
    assign bus.rd_data = bus.rd_empty ? '0 : mem[rd_addr];
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rd_q;
    always_ff @(posedge clk) begin
      if (!rstn)       rd_q <= '0;
      else if (rd_acc) rd_q <= mem[rd_addr];
    end
    assign bus.rd_data = rd_q;
  end

endmodule

// File: tb/tb_udp_cmd_sync_fifo_param.sv
// Randomised bench: standard and FWFT instances driven in lockstep against a queue model.
module tb_udp_cmd_sync_fifo_param;
  import udp_fifo_pkg::*;

  localparam int unsigned DW    = 33;
  localparam int unsigned AW    = 6;
  localparam int          DEPTH = 64;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  udp_cmd_sync_fifo_param_if #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW)) bs ();
  udp_cmd_sync_fifo_param_if #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW)) bf ();

  udp_cmd_sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .FWFT(FIFO_MODE_STD)) u_std (
    .clk(clk), .rstn(rstn), .bus(bs));
  udp_cmd_sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .FWFT(FIFO_MODE_FWFT)) u_fwft (
    .clk(clk), .rstn(rstn), .bus(bf));

  // Reference model: contents as a queue, plus sticky flags and the last popped word.
  logic [DW-1:0] q[$];
  bit            m_ovf;
  bit            m_udf;
  logic [DW-1:0] m_rd;
  int            af_t;
  int            ae_t;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    else             n_pass++;
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return DW'({$urandom(), $urandom()});
  endfunction

  task automatic model_step(input bit f, input bit w, input bit r, input logic [DW-1:0] d,
                            input bit ec);
    bit full, empty;
    full  = (q.size() == DEPTH);
    empty = (q.size() == 0);
    if (!rstn) begin
      q.delete();
      m_ovf = 0;
      m_udf = 0;
      m_rd  = '0;
    end else begin
      if (f) begin
        q.delete();
      end else begin
        if (r && !empty) m_rd = q.pop_front();
        if (w && !full)  q.push_back(d);
      end
      if (!f && w && full)  m_ovf = 1;
      else if (ec)          m_ovf = 0;
      if (!f && r && empty) m_udf = 1;
      else if (ec)          m_udf = 0;
    end
  endtask

  task automatic check_all(input string tag);
    int lv;
    lv = q.size();
    chk({tag, ":s_level"},  64'(bs.level),        64'(lv));
    chk({tag, ":f_level"},  64'(bf.level),        64'(lv));
    chk({tag, ":s_full"},   64'(bs.wr_full),      64'(lv == DEPTH));
    chk({tag, ":f_full"},   64'(bf.wr_full),      64'(lv == DEPTH));
    chk({tag, ":s_empty"},  64'(bs.rd_empty),     64'(lv == 0));
    chk({tag, ":f_empty"},  64'(bf.rd_empty),     64'(lv == 0));
    chk({tag, ":s_afull"},  64'(bs.almost_full),  64'(lv >= af_t));
    chk({tag, ":f_afull"},  64'(bf.almost_full),  64'(lv >= af_t));
    chk({tag, ":s_aempty"}, 64'(bs.almost_empty), 64'(lv <= ae_t));
    chk({tag, ":f_aempty"}, 64'(bf.almost_empty), 64'(lv <= ae_t));
    chk({tag, ":s_ovf"},    64'(bs.overflow),     64'(m_ovf));
    chk({tag, ":f_ovf"},    64'(bf.overflow),     64'(m_ovf));
    chk({tag, ":s_udf"},    64'(bs.underflow),    64'(m_udf));
    chk({tag, ":f_udf"},    64'(bf.underflow),    64'(m_udf));
    chk({tag, ":s_rdata"},  64'(bs.rd_data),      64'(m_rd));
    if (lv != 0) chk({tag, ":f_rdata"}, 64'(bf.rd_data), 64'(q[0]));
  endtask

  // Drive one cycle of stimulus to both instances, advance the model, then check after the edge.
  task automatic cyc(input string tag, input bit f, input bit w, input bit r,
                     input logic [DW-1:0] d, input bit ec);
    bs.flush = f;  bs.wr_en = w;  bs.rd_en = r;  bs.wr_data = d;  bs.err_clr = ec;
    bf.flush = f;  bf.wr_en = w;  bf.rd_en = r;  bf.wr_data = d;  bf.err_clr = ec;
    bs.af_thresh = 7'(af_t);  bf.af_thresh = 7'(af_t);
    bs.ae_thresh = 7'(ae_t);  bf.ae_thresh = 7'(ae_t);
    model_step(f, w, r, d, ec);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic goto_level(input string tag, input int n);
    while (q.size() < n) cyc(tag, 0, 1, 0, rnd_word(), 0);
    while (q.size() > n) cyc(tag, 0, 0, 1, '0, 0);
  endtask

  initial begin
    af_t = 60;
    ae_t = 4;
    rstn = 1'b0;
    cyc("reset", 0, 0, 0, '0, 0);
    cyc("reset", 0, 1, 1, '0, 0);
    chk("reset_f_rdata", 64'(bf.rd_data), 64'h0);
    rstn = 1'b1;

    for (int i = 0; i < DEPTH; i++) cyc("fill", 0, 1, 0, DW'(i), 0);
    chk("fill_full", 64'(bs.wr_full), 64'h1);
    cyc("overflow", 0, 1, 0, DW'(33'h1_5555_AAAA), 0);
    chk("ovf_level", 64'(bs.level), 64'd64);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_head", 64'(bf.rd_data), 64'(i));
      cyc("drain", 0, 0, 1, '0, 0);
      chk("drain_data", 64'(bs.rd_data), 64'(i));
    end
    cyc("err_clr", 0, 0, 0, '0, 1);

    goto_level("to10", 10);
    for (int i = 0; i < 20; i++) cyc("simul", 0, 1, 1, rnd_word(), 0);
    chk("simul_level", 64'(bs.level), 64'd10);

    goto_level("to0", 0);
    cyc("simul_empty", 0, 1, 1, rnd_word(), 0);
    chk("simul_empty_lvl", 64'(bs.level), 64'd1);
    goto_level("to64", 64);
    cyc("simul_full", 0, 1, 1, rnd_word(), 0);
    chk("simul_full_lvl", 64'(bs.level), 64'd63);
    cyc("err_clr2", 0, 0, 0, '0, 1);

    goto_level("to59", 59);
    cyc("af_rise", 0, 1, 0, rnd_word(), 0);
    chk("af_at60", 64'(bf.almost_full), 64'h1);
    goto_level("to5", 5);
    cyc("ae_rise", 0, 0, 1, '0, 0);
    chk("ae_at4", 64'(bs.almost_empty), 64'h1);
    af_t = 0;
    cyc("af_zero", 0, 0, 0, '0, 0);
    chk("af_zero_on", 64'(bs.almost_full), 64'h1);
    ae_t = 64;
    goto_level("ae_big", 64);
    chk("ae_big_on", 64'(bf.almost_empty), 64'h1);
    af_t = 60;
    ae_t = 4;

    goto_level("to30", 30);
    cyc("flush", 1, 1, 1, rnd_word(), 0);
    chk("flush_empty", 64'(bs.rd_empty), 64'h1);
    cyc("underflow", 0, 0, 1, '0, 0);
    chk("udf_set", 64'(bf.underflow), 64'h1);
    cyc("udf_clr", 0, 0, 0, '0, 1);

    goto_level("pre_rst", 20);
    rstn = 1'b0;
    cyc("mid_reset", 0, 1, 1, rnd_word(), 0);
    rstn = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      int  wp;
      bit  f, w, r, ec;
      wp = ((i / 250) % 2 == 0) ? 75 : 25;
      f  = ($urandom_range(99) < 2);
      w  = ($urandom_range(99) < wp);
      r  = ($urandom_range(99) < 50);
      ec = ($urandom_range(99) < 5);
      if ($urandom_range(99) < 3) begin
        af_t = $urandom_range(DEPTH);
        ae_t = $urandom_range(DEPTH);
      end
      rstn = ($urandom_range(999) < 5) ? 1'b0 : 1'b1;
      cyc("rand", f, w, r, rnd_word(), ec);
    end
    rstn = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
